// File: rtl/pc_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_seq_pkg                                                           |
// | Branch condition codes, NZCV bit positions, sequencer state encoding |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pc_seq_pkg;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] ST_RST      = 2'd0;
    localparam logic [1:0] ST_FETCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;
    localparam logic [1:0] ST_FLUSH    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_cond.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_cond_eval                                                     |
// | Combinational evaluation of a 4-bit condition code against NZCV      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module branch_cond_eval
    import pc_seq_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       take
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = nzcv[FLAG_N];
    assign w_z = nzcv[FLAG_Z];
    assign w_c = nzcv[FLAG_C];
    assign w_v = nzcv[FLAG_V];

    always_comb begin
        take = 1'b0;
        case (cond)
            COND_EQ: take = w_z;
            COND_NE: take = ~w_z;
            COND_CS: take = w_c;
            COND_CC: take = ~w_c;
            COND_MI: take = w_n;
            COND_PL: take = ~w_n;
            COND_VS: take = w_v;
            COND_VC: take = ~w_v;
            COND_HI: take = w_c & ~w_z;
            COND_LS: take = ~w_c | w_z;
            COND_GE: take = (w_n == w_v);
            COND_LT: take = (w_n != w_v);
            COND_GT: take = ~w_z & (w_n == w_v);
            COND_LE: take = w_z | (w_n != w_v);
            COND_AL: take = 1'b1;
            default: take = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_sequencer                                                         |
// | Program counter, NZCV flags, fetch handshake and branch redirect     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int RESET_PC     = 0,
    parameter int PC_INC       = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    output logic            if_valid,
    input  logic            stall,
    input  logic            br_valid,
    input  logic [3:0]      br_cond,
    input  logic [PC_W-1:0] br_target,
    input  logic            flag_we,
    input  logic [3:0]      alu_flags,
    output logic [3:0]      flags,
    output logic            br_taken,
    output logic            flush
);

    localparam int c_cnt_w = $clog2(FLUSH_CYCLES + 1);

    logic [1:0]         r_state;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_addr;
    logic [3:0]         r_flags;
    logic               r_discard;
    logic               r_outst;
    logic               r_flush;
    logic [c_cnt_w-1:0] r_flush_cnt;
    logic               r_if_valid;
    logic               r_br_taken;

    logic               w_issue;
    logic               w_ack;
    logic               w_cond;
    logic               w_taken;
    logic               w_flush_done;
    logic [3:0]         w_eff_flags;

    // Same-cycle ALU flags take priority so a compare-and-branch pair needs no bubble.
    assign w_eff_flags = flag_we ? alu_flags : r_flags;

    branch_cond_eval u_cond (
        .cond (br_cond),
        .nzcv (w_eff_flags),
        .take (w_cond)
    );

    assign w_taken      = br_valid & ~r_flush & w_cond;
    assign w_issue      = (r_state == ST_FETCH) & ~stall & ~r_flush;
    assign imem_req     = w_issue | r_outst;
    assign imem_addr    = r_outst ? r_addr : r_pc;
    assign w_ack        = imem_ack & imem_req;
    assign w_flush_done = ~r_flush | (r_flush_cnt == '0);

    assign if_valid = r_if_valid;
    assign br_taken = r_br_taken;
    assign flush    = r_flush;
    assign flags    = r_flags;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RST;
            r_pc        <= PC_W'(RESET_PC);
            r_addr      <= PC_W'(RESET_PC);
            r_flags     <= 4'b0000;
            r_discard   <= 1'b0;
            r_outst     <= 1'b0;
            r_flush     <= 1'b0;
            r_flush_cnt <= '0;
            r_if_valid  <= 1'b0;
            r_br_taken  <= 1'b0;
        end else begin
            r_br_taken <= w_taken;
            r_if_valid <= w_ack & ~r_discard & ~w_taken;

            if (flag_we) begin
                r_flags <= alu_flags;
            end

            // r_addr keeps the in-flight address stable even after pc is redirected.
            if (w_ack) begin
                r_outst <= 1'b0;
            end else if (w_issue) begin
                r_outst <= 1'b1;
                r_addr  <= r_pc;
            end

            if (w_taken) begin
                r_discard <= imem_req & ~imem_ack;
            end else if (w_ack) begin
                r_discard <= 1'b0;
            end

            if (w_taken) begin
                r_pc <= br_target;
            end else if (w_ack && !r_discard) begin
                r_pc <= r_pc + PC_W'(PC_INC);
            end

            if (w_taken) begin
                r_flush     <= 1'b1;
                r_flush_cnt <= c_cnt_w'(FLUSH_CYCLES - 1);
            end else if (r_flush) begin
                if (r_flush_cnt != '0) begin
                    r_flush_cnt <= r_flush_cnt - c_cnt_w'(1);
                end else begin
                    r_flush <= 1'b0;
                end
            end

            case (r_state)
                ST_RST:      r_state <= ST_FETCH;
                ST_FETCH:    if (w_issue && !imem_ack) r_state <= ST_WAIT_ACK;
                ST_WAIT_ACK: if (imem_ack) r_state <= ST_FETCH;
                ST_FLUSH:    if (w_flush_done && (!r_outst || imem_ack)) r_state <= ST_FETCH;
                default:     r_state <= ST_RST;
            endcase

            if (w_taken) begin
                r_state <= ST_FLUSH;
            end
        end
    end

endmodule
`default_nettype wire
